// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use stall, mispredict flush, HALT drain and debug gating for the 5-stage core
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mispredict,
  input  logic             dbg_run,
  input  logic             dbg_step,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_enable,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state, state_nx;
  logic [DW-1:0] drain_cnt, drain_nx;
  logic en, load_use, stall_inc, flush_inc;
  assign en = dbg_run | dbg_step;
  assign load_use = ex_mem_read & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  always_comb begin
    pc_write = 1'b0;
    pc_redirect = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_enable = 1'b0;
    halted = !reset && state == HALTED;
    state_nx = state;
    drain_nx = drain_cnt;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (!reset && en && state == RUN) begin
      pipe_enable = 1'b1;
      if (ex_mispredict) begin
        pc_write = 1'b1;
        pc_redirect = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        id_ex_flush = 1'b1;
        stall_inc = 1'b1;
      end else if (id_halt) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        drain_nx = DW'(DRAIN_CYCLES);
        state_nx = DRAIN;
      end else begin
        pc_write = 1'b1;
        if_id_write = 1'b1;
      end
    end else if (!reset && en && state == DRAIN) begin
      // EX holds only bubbles here, so a mispredict indication is stale
      pipe_enable = 1'b1;
      id_ex_flush = 1'b1;
      drain_nx = drain_cnt - DW'(1);
      state_nx = drain_cnt == DW'(1) ? HALTED : DRAIN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      drain_cnt <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nx;
      drain_cnt <= drain_nx;
      if (stall_inc && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (flush_inc && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed plus randomized checks against a cycle-level reference model
module tb_pipeline_hazard_ctrl;
  localparam int DC = 3;
  localparam int CW = 3;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, reset = 1;
  logic [4:0] id_rs = 0, id_rt = 0, ex_rt = 0;
  logic id_uses_rt = 0, id_halt = 0, ex_mem_read = 0, ex_mispredict = 0, dbg_run = 1, dbg_step = 0;
  logic pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, pipe_enable, halted;
  logic [CW-1:0] stall_count, flush_count;
  int n_cmp = 0, n_bad = 0;
  int m_state = 0, m_drain = 0, m_stall = 0, m_flush = 0;
  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_mispredict(ex_mispredict),
    .dbg_run(dbg_run), .dbg_step(dbg_step), .pc_write(pc_write), .pc_redirect(pc_redirect),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pipe_enable(pipe_enable), .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic lu();
    return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction
  // {pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, pipe_enable, halted}
  function automatic logic [6:0] exp_out();
    if (reset) return 7'b0000000;
    if (m_state == 2) return 7'b0000001;
    if (!(dbg_run || dbg_step)) return 7'b0000000;
    if (m_state == 1) return 7'b0000110;
    if (ex_mispredict) return 7'b1101110;
    if (lu()) return 7'b0000110;
    if (id_halt) return 7'b0001110;
    return 7'b1010010;
  endfunction
  task automatic cyc(input string tag);
    int ns, nd, nst, nfl;
    #3;
    check({tag, ".out"}, 32'({pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_flush, pipe_enable, halted}), 32'(exp_out()));
    check({tag, ".stall"}, 32'(stall_count), 32'(m_stall));
    check({tag, ".flush"}, 32'(flush_count), 32'(m_flush));
    ns = m_state; nd = m_drain; nst = m_stall; nfl = m_flush;
    if (reset) begin
      ns = 0; nd = 0; nst = 0; nfl = 0;
    end else if (m_state != 2 && (dbg_run || dbg_step)) begin
      if (m_state == 1) begin
        nd = m_drain - 1;
        if (nd == 0) ns = 2;
      end else if (ex_mispredict) nfl = m_flush < MAXC ? m_flush + 1 : MAXC;
      else if (lu()) nst = m_stall < MAXC ? m_stall + 1 : MAXC;
      else if (id_halt) begin
        ns = 1; nd = DC;
      end
    end
    @(posedge clk);
    #1;
    m_state = ns; m_drain = nd; m_stall = nst; m_flush = nfl;
  endtask
  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; id_halt = 0;
    ex_mem_read = 0; ex_mispredict = 0; dbg_run = 1; dbg_step = 0; reset = 0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc("reset_hold");
    idle();
    cyc("after_reset");
    ex_mem_read = 1; ex_rt = 2; id_rs = 2;
    cyc("lu_rs");
    idle();
    cyc("lu_next_normal");
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    cyc("lu_rt_zero");
    ex_rt = 2; id_rs = 5; id_rt = 2; id_uses_rt = 0;
    cyc("lu_rt_unused");
    id_uses_rt = 1;
    cyc("lu_rt_used");
    ex_mispredict = 1; id_halt = 1; id_rs = 2;
    cyc("mis_prio");
    idle();
    cyc("mis_stay_run");
    dbg_run = 0; ex_mem_read = 1; ex_rt = 3; id_rs = 3;
    repeat (3) cyc("dbg_gated");
    dbg_step = 1;
    cyc("dbg_step");
    dbg_step = 0;
    cyc("dbg_after_step");
    idle();
    id_halt = 1;
    cyc("halt_accept");
    ex_mispredict = 1;
    repeat (DC) cyc("drain");
    ex_mispredict = 0;
    repeat (2) cyc("halted");
    reset = 1;
    cyc("halt_reset");
    idle();
    ex_mem_read = 1; ex_rt = 7; id_rs = 7;
    repeat (MAXC + 3) cyc("stall_sat");
    idle();
    ex_mispredict = 1;
    repeat (MAXC + 2) cyc("flush_sat");
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 59) == 0;
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom);
      ex_mem_read = 1'($urandom);
      ex_mispredict = $urandom_range(0, 5) == 0;
      id_halt = $urandom_range(0, 15) == 0;
      dbg_run = $urandom_range(0, 3) != 0;
      dbg_step = $urandom_range(0, 2) == 0;
      cyc("rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
